// File: rtl/nor_shift_register_if.sv
// Load/shift bundle for nor_shift_register.
// Master drives the request side, slave returns the register view.
interface nor_shift_register_if #(
  parameter int WIDTH = 8
);
  logic             LOAD;
  logic [WIDTH-1:0] PD;
  logic             START;
  logic             SI;
  logic             SO;
  logic [WIDTH-1:0] Q;
  logic             BUSY;
  logic             DONE;

  modport master (
    output LOAD,
    output PD,
    output START,
    output SI,
    input  SO,
    input  Q,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  LOAD,
    input  PD,
    input  START,
    input  SI,
    output SO,
    output Q,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/nor_shift_register.sv
// WIDTH-bit register bank with parallel load and a self-timed
// serial transfer of exactly WIDTH shifts per START.
module nor_shift_register #(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit             MSB_FIRST = 1'b1
) (
  input logic C,
  input logic RN,
  nor_shift_register_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] q_sh;
  logic             busy;
  logic             busy_nx;
  logic             done;
  logic             done_nx;
  logic             so;

  logic idle;
  logic ld;
  logic st;
  logic shifting;
  logic last;

  generate
    if (MSB_FIRST) begin : g_msb
      assign q_sh = {q[WIDTH-2:0], bus.SI};
      assign so   = q[WIDTH-1];
    end else begin : g_lsb
      assign q_sh = {bus.SI, q[WIDTH-1:1]};
      assign so   = q[0];
    end
  endgenerate

  // FIN accepts requests exactly like IDLE so transfers can chain
  assign idle     = (state == S_IDLE) || (state == S_FIN);
  assign ld       = idle && bus.LOAD;
  assign st       = idle && !bus.LOAD && bus.START;
  assign shifting = (state == S_SHIFT);
  assign last     = (cnt == LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    q_nx     = q;
    busy_nx  = busy;
    done_nx  = 1'b0;
    unique case (1'b1)
      ld: begin
        q_nx     = bus.PD;
        state_nx = S_IDLE;
      end
      st: begin
        cnt_nx   = '0;
        busy_nx  = 1'b1;
        state_nx = S_SHIFT;
      end
      shifting: begin
        q_nx = q_sh;
        if (last) begin
          state_nx = S_FIN;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state <= S_IDLE;
      cnt   <= '0;
      q     <= RESET_VAL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      q     <= q_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  assign bus.Q    = q;
  assign bus.SO   = so;
  assign bus.BUSY = busy;
  assign bus.DONE = done;

endmodule
